// File: rtl/store_datapath_pkg.sv
// Shared constants and helpers for the squeeze-side serializer: lane width, rates,
// mode encodings and the byte-order switch used on every outgoing word.
package store_datapath_pkg;

  localparam int w              = 64;
  localparam int RATE_SHAKE128  = 1344;
  localparam int RATE_SHAKE256  = 1088;
  localparam int WORDS_SHAKE128 = 21;
  localparam int WORDS_SHAKE256 = 17;

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b00;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

  // Keccak lanes are little-endian; the bus wants the first stream byte in the MSBs.
  function automatic logic [w-1:0] EndianSwitcher(input logic [w-1:0] x);
    logic [w-1:0] y;
    y = '0;
    for (int i = 0; i < w / 8; i++) begin
      y[8*i +: 8] = x[w-8-8*i +: 8];
    end
    return y;
  endfunction

  // Any encoding other than SHAKE256 drains the full SHAKE128 rate.
  function automatic logic [4:0] words_per_block(input logic [1:0] mode);
    return (mode == SHAKE256_MODE_VEC) ? 5'(WORDS_SHAKE256) : 5'(WORDS_SHAKE128);
  endfunction

endpackage

// File: rtl/store_datapath_piso_buffer.sv
// Parallel-in/serial-out lane buffer: loads a whole rate block, presents lane 0 first
// and shifts the next lane down on every accepted word.
module piso_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 21
) (
  input  logic                   clk,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic                   shift,
  output logic [WIDTH-1:0]       head
);

  logic [WIDTH*DEPTH-1:0] lanes_q;

  // Pure datapath storage; contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      lanes_q <= load_data;
    end else if (shift) begin
      lanes_q <= {{WIDTH{1'b0}}, lanes_q[WIDTH*DEPTH-1:WIDTH]};
    end
  end

  assign head = lanes_q[WIDTH-1:0];

endmodule

// File: rtl/store_datapath.sv
// SHAKE squeeze serializer: drains rate blocks as big-endian bus words, counts down the
// requested length, masks the final partial word and asks for more permutations as needed.
module store_datapath
  import store_datapath_pkg::*;
#(
  parameter int W      = w,
  parameter int SIZE_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RATE_SHAKE128-1:0] rate_i,
  input  logic [1:0]               operation_mode_i,
  input  logic [SIZE_W-1:0]        output_size_i,
  input  logic                     block_valid_i,
  output logic                     block_ready_o,
  output logic [W-1:0]             data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic                     squeeze_request_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, WAIT_BLOCK} state_e;

  localparam int LANES = RATE_SHAKE128 / W;

  state_e            state_q, state_d;
  logic [1:0]        mode_q;
  logic [SIZE_W-1:0] size_q;
  logic [4:0]        word_cnt_q;
  logic              done_q, squeeze_q;
  logic              load, shift, accept, xfer;
  logic              last_of_job, last_of_blk;
  logic [W-1:0]      head, swapped, mask;
  logic [3:0]        nbytes;

  piso_buffer #(.WIDTH(W), .DEPTH(LANES)) u_piso (
    .clk       (clk),
    .load      (load),
    .load_data (rate_i),
    .shift     (shift),
    .head      (head)
  );

  assign block_ready_o = (state_q != DRAIN);
  assign valid_o       = (state_q == DRAIN);
  assign accept        = block_valid_i && block_ready_o;
  assign xfer          = valid_o && ready_i;
  assign last_of_job   = (size_q <= SIZE_W'(W));
  assign last_of_blk   = (word_cnt_q == 5'(words_per_block(mode_q) - 5'd1));

  // Remaining length is a whole number of bytes; a zero byte field means a full word.
  assign nbytes  = (size_q[5:3] == 3'd0) ? 4'd8 : {1'b0, size_q[5:3]};
  assign mask    = ~({W{1'b1}} >> {nbytes, 3'b000});
  assign swapped = EndianSwitcher(head);
  assign data_o  = valid_o ? (last_of_job ? (swapped & mask) : swapped) : '0;
  assign last_o  = valid_o && last_of_job;

  assign done_o            = done_q;
  assign squeeze_request_o = squeeze_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (output_size_i != '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          shift = 1'b1;
          // Job end takes priority over block end: no further permutation needed.
          if (last_of_job)      state_d = IDLE;
          else if (last_of_blk) state_d = WAIT_BLOCK;
        end
      end
      WAIT_BLOCK: begin
        if (accept) begin
          load    = 1'b1;
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      size_q     <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      squeeze_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      squeeze_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q     <= operation_mode_i;
            size_q     <= output_size_i;
            word_cnt_q <= '0;
            if (output_size_i == '0) done_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (xfer) begin
            size_q     <= last_of_job ? '0 : size_q - SIZE_W'(W);
            word_cnt_q <= word_cnt_q + 5'd1;
            if (last_of_job)      done_q    <= 1'b1;
            else if (last_of_blk) squeeze_q <= 1'b1;
          end
        end
        WAIT_BLOCK: begin
          if (accept) word_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_datapath.sv
// Self-checking bench for store_datapath: random rate blocks, a byte-stream reference model
// and per-scenario checks of words, last/done/squeeze behaviour, stalls and reset.
module tb_store_datapath;
  import store_datapath_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [1343:0] rate_i;
  logic [1:0]    operation_mode_i;
  logic [31:0]   output_size_i;
  logic          block_valid_i;
  logic          block_ready_o;
  logic [63:0]   data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          squeeze_request_o;
  logic          done_o;

  store_datapath #(.W(64), .SIZE_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .rate_i            (rate_i),
    .operation_mode_i  (operation_mode_i),
    .output_size_i     (output_size_i),
    .block_valid_i     (block_valid_i),
    .block_ready_o     (block_ready_o),
    .data_o            (data_o),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .last_o            (last_o),
    .squeeze_request_o (squeeze_request_o),
    .done_o            (done_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] blk [0:3][0:20];
  logic [63:0] got_w[$];
  logic        got_l[$];
  logic [63:0] exp_w[$];
  int n_sq, n_done, n_valid, n_acc, stab_viol, timed_out;
  int first_acc_cyc, first_valid_cyc;
  int exp_sq, exp_blocks;

  // Reference: the output is simply the first size/8 bytes of the concatenated rate blocks,
  // each block contributing rate/8 bytes in lane/byte order, packed MSB-first into words.
  function automatic void build_expected(input logic [1:0] mode, input int size);
    int wpb, nb, bi, bpb;
    logic [63:0] wd;
    wpb = (mode == SHAKE256_MODE_VEC) ? 17 : 21;
    bpb = wpb * 8;
    nb  = size / 8;
    exp_w.delete();
    for (int i = 0; i < nb; i += 8) begin
      wd = '0;
      for (int j = 0; j < 8; j++) begin
        bi = i + j;
        if (bi < nb) wd[63-8*j -: 8] = blk[bi / bpb][(bi % bpb) / 8][8*(bi % 8) +: 8];
      end
      exp_w.push_back(wd);
    end
    exp_blocks = (nb == 0) ? 1 : (nb + bpb - 1) / bpb;
    exp_sq     = exp_blocks - 1;
  endfunction

  task automatic idle_inputs();
    block_valid_i    = 1'b0;
    ready_i          = 1'b0;
    rate_i           = '0;
    operation_mode_i = '0;
    output_size_i    = '0;
  endtask

  // Runs one job, recording everything observed on the output side.
  task automatic run_job(input logic [1:0] mode, input int size, input int stall_pct);
    logic acc, xfer, cap_l, prev_stall, prev_l;
    logic [63:0] cap_d, prev_d;
    int post;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 21; k++) blk[b][k] = {$urandom, $urandom};
    got_w.delete(); got_l.delete();
    n_sq = 0; n_done = 0; n_valid = 0; n_acc = 0; stab_viol = 0; timed_out = 0;
    first_acc_cyc = -1; first_valid_cyc = -1;
    post = -1; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done_o) n_done++;
      if (squeeze_request_o) n_sq++;
      if (valid_o) begin
        n_valid++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall && (!valid_o || data_o !== prev_d || last_o !== prev_l)) stab_viol++;
      if (post >= 0) begin
        if (post == 3) break;
        post++;
      end
      if (post < 0 && n_acc < 4) begin
        for (int k = 0; k < 21; k++) rate_i[64*k +: 64] = blk[n_acc][k];
        operation_mode_i = mode;
        output_size_i    = size;
        block_valid_i    = ($urandom_range(99) >= stall_pct / 2);
      end else begin
        block_valid_i = 1'b0;
      end
      ready_i    = ($urandom_range(99) >= stall_pct);
      acc        = block_valid_i && block_ready_o;
      xfer       = valid_o && ready_i;
      cap_d      = data_o;
      cap_l      = last_o;
      prev_stall = valid_o && !ready_i;
      prev_d     = data_o;
      prev_l     = last_o;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (size == 0) post = 0;
      end
      if (xfer) begin
        got_w.push_back(cap_d);
        got_l.push_back(cap_l);
        if (cap_l) post = 0;
      end
    end
    if (post < 0) timed_out = 1;
    idle_inputs();
    build_expected(mode, size);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset valid_o got %b want 0", valid_o); end
    vectors++; if (block_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset block_ready_o got %b want 1", block_ready_o); end
    vectors++; if (last_o !== 1'b0) begin miscompares++; $display("FAIL reset last_o got %b want 0", last_o); end
    vectors++; if (done_o !== 1'b0 || squeeze_request_o !== 1'b0) begin miscompares++; $display("FAIL reset pulses got done=%b sq=%b want 0/0", done_o, squeeze_request_o); end
    vectors++; if (data_o !== 64'h0) begin miscompares++; $display("FAIL reset data_o got %h want 0", data_o); end
    rst = 1'b0;
  endtask

  task automatic test_short128();
    run_job(SHAKE128_MODE_VEC, 256, 0);
    vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL short128 timeout got %0d want 0", timed_out); end
    vectors++; if (got_w.size() !== 4) begin miscompares++; $display("FAIL short128 words got %0d want 4", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        miscompares++; $display("FAIL short128 word%0d got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      end
    end
    vectors++; if (got_w.size() > 0 && got_w[0] !== {blk[0][0][7:0], blk[0][0][15:8], blk[0][0][23:16], blk[0][0][31:24], blk[0][0][39:32], blk[0][0][47:40], blk[0][0][55:48], blk[0][0][63:56]}) begin
      miscompares++; $display("FAIL short128 lane0 swap got %h", got_w[0]); end
    vectors++; if (first_valid_cyc !== first_acc_cyc + 1) begin miscompares++; $display("FAIL short128 latency got valid@%0d want %0d", first_valid_cyc, first_acc_cyc + 1); end
    vectors++; if (n_done !== 1 || n_sq !== 0) begin miscompares++; $display("FAIL short128 done/sq got %0d/%0d want 1/0", n_done, n_sq); end
  endtask

  task automatic test_multi256();
    run_job(SHAKE256_MODE_VEC, 1152, 0);
    vectors++; if (timed_out !== 0) begin miscompares++; $display("FAIL multi256 timeout got %0d want 0", timed_out); end
    vectors++; if (got_w.size() !== 18) begin miscompares++; $display("FAIL multi256 words got %0d want 18", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        miscompares++; $display("FAIL multi256 word%0d got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      end
    end
    vectors++; if (n_sq !== exp_sq || n_sq !== 1) begin miscompares++; $display("FAIL multi256 squeeze got %0d want %0d", n_sq, exp_sq); end
    vectors++; if (n_acc !== exp_blocks || n_done !== 1) begin miscompares++; $display("FAIL multi256 blocks/done got %0d/%0d want %0d/1", n_acc, n_done, exp_blocks); end
  endtask

  task automatic test_full_block();
    run_job(SHAKE128_MODE_VEC, 1344, 0);
    vectors++; if (got_w.size() !== 21 || timed_out !== 0) begin miscompares++; $display("FAIL fullblk words got %0d (to=%0d) want 21", got_w.size(), timed_out); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        miscompares++; $display("FAIL fullblk word%0d got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      end
    end
    vectors++; if (n_sq !== 0) begin miscompares++; $display("FAIL fullblk squeeze got %0d want 0", n_sq); end
    vectors++; if (n_done !== 1 || n_acc !== 1) begin miscompares++; $display("FAIL fullblk done/blocks got %0d/%0d want 1/1", n_done, n_acc); end
  endtask

  task automatic test_partial();
    logic [63:0] want1;
    run_job(SHAKE128_MODE_VEC, 72, 0);
    want1 = {blk[0][1][7:0], 56'h0};
    vectors++; if (got_w.size() !== 2 || timed_out !== 0) begin miscompares++; $display("FAIL partial words got %0d (to=%0d) want 2", got_w.size(), timed_out); end
    vectors++; if (got_w.size() > 0 && (got_w[0] !== exp_w[0] || got_l[0] !== 1'b0)) begin miscompares++; $display("FAIL partial word0 got %h/%b want %h/0", got_w[0], got_l[0], exp_w[0]); end
    vectors++; if (got_w.size() > 1 && (got_w[1] !== want1 || got_l[1] !== 1'b1)) begin miscompares++; $display("FAIL partial word1 got %h/%b want %h/1", got_w[1], got_l[1], want1); end
    vectors++; if (n_done !== 1 || n_sq !== 0) begin miscompares++; $display("FAIL partial done/sq got %0d/%0d want 1/0", n_done, n_sq); end
  endtask

  task automatic test_unknown_mode();
    run_job(2'b10, 1344 + 128 + 24, 0);
    vectors++; if (got_w.size() !== exp_w.size() || timed_out !== 0) begin miscompares++; $display("FAIL unkmode words got %0d want %0d", got_w.size(), exp_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        miscompares++; $display("FAIL unkmode word%0d got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      end
    end
    vectors++; if (n_sq !== 1 || n_acc !== 2) begin miscompares++; $display("FAIL unkmode sq/blocks got %0d/%0d want 1/2", n_sq, n_acc); end
  endtask

  task automatic test_backpressure();
    for (int rep = 0; rep < 3; rep++) begin
      run_job(SHAKE128_MODE_VEC, 512, 45);
      vectors++; if (timed_out !== 0 || got_w.size() !== 8) begin miscompares++; $display("FAIL bp%0d words got %0d (to=%0d) want 8", rep, got_w.size(), timed_out); end
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
        vectors++;
        if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
          miscompares++; $display("FAIL bp%0d word%0d got %h/%b want %h/%b", rep, i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
        end
      end
      vectors++; if (stab_viol !== 0) begin miscompares++; $display("FAIL bp%0d stall stability violations got %0d want 0", rep, stab_viol); end
      vectors++; if (n_done !== 1 || n_sq !== 0) begin miscompares++; $display("FAIL bp%0d done/sq got %0d/%0d want 1/0", rep, n_done, n_sq); end
    end
  endtask

  task automatic test_zero();
    run_job(SHAKE256_MODE_VEC, 0, 0);
    vectors++; if (timed_out !== 0 || n_acc !== 1) begin miscompares++; $display("FAIL zero accept got %0d (to=%0d) want 1", n_acc, timed_out); end
    vectors++; if (n_valid !== 0 || got_w.size() !== 0) begin miscompares++; $display("FAIL zero valid cycles got %0d want 0", n_valid); end
    vectors++; if (n_done !== 1 || n_sq !== 0) begin miscompares++; $display("FAIL zero done/sq got %0d/%0d want 1/0", n_done, n_sq); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    for (int k = 0; k < 42; k++) rate_i[32*k +: 32] = $urandom;
    operation_mode_i = SHAKE128_MODE_VEC;
    output_size_i    = 512;
    block_valid_i    = 1'b1;
    ready_i          = 1'b1;
    @(posedge clk); #1;
    block_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL rstmid pre valid_o got %b want 1", valid_o); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (valid_o !== 1'b0 || last_o !== 1'b0) begin miscompares++; $display("FAIL rstmid valid/last got %b/%b want 0/0", valid_o, last_o); end
    vectors++; if (block_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid block_ready_o got %b want 1", block_ready_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    vectors++; if (valid_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL rstmid post valid/done got %b/%b want 0/0", valid_o, done_o); end
    run_job(SHAKE128_MODE_VEC, 512, 0);
    vectors++; if (got_w.size() !== 8 || timed_out !== 0) begin miscompares++; $display("FAIL rstmid next words got %0d want 8", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
      vectors++;
      if (got_w[i] !== exp_w[i] || got_l[i] !== (i == exp_w.size() - 1)) begin
        miscompares++; $display("FAIL rstmid next word%0d got %h/%b want %h/%b", i, got_w[i], got_l[i], exp_w[i], i == exp_w.size() - 1);
      end
    end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL rstmid next done got %0d want 1", n_done); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_short128();
    test_multi256();
    test_full_block();
    test_partial();
    test_unknown_mode();
    test_backpressure();
    test_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
